// File: rtl/ibex_wb_port_arbiter.sv
// Shared register-file write port arbiter.
// Sources: LSU load data (never stalls), the EX result handshake, and a small FIFO
// that buffers multi-cycle FPU results. The LSU always wins. EX normally beats the
// FIFO. Once the FIFO head has lost StarveLimit cycles in a row, the FIFO beats EX.
module ibex_wb_port_arbiter #(
    parameter int unsigned FifoDepth   = 2,
    parameter int unsigned StarveLimit = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        lsu_we_i,
    input  logic [4:0]  lsu_waddr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic        lsu_fp_i,

    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [4:0]  ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic        ex_fp_i,

    input  logic        fpu_valid_i,
    output logic        fpu_ready_o,
    input  logic [4:0]  fpu_waddr_i,
    input  logic [31:0] fpu_wdata_i,

    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        rf_fp_o,

    output logic        fpu_pending_o
);

    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW = $clog2(FifoDepth + 1);
    localparam int unsigned StvW = $clog2(StarveLimit + 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(FifoDepth - 1);

    // Each entry holds {waddr, wdata}. The data storage has no reset.
    logic [36:0]     mem_reg [FifoDepth];
    logic [PtrW-1:0] wptr_reg, wptr_next;
    logic [PtrW-1:0] rptr_reg, rptr_next;
    logic [CntW-1:0] cnt_reg, cnt_next;
    logic [StvW-1:0] stv_reg, stv_next;

    logic fifo_nonempty, fifo_full, starved;
    logic push, pop;
    logic gnt_lsu, gnt_ex, gnt_fifo;
    logic [36:0] head;

    assign fifo_nonempty = (cnt_reg != '0);
    assign fifo_full     = (cnt_reg == CntW'(FifoDepth));
    assign starved       = (stv_reg == StvW'(StarveLimit));
    assign head          = mem_reg[rptr_reg];

    // fpu_ready_o depends only on registered occupancy. A full buffer therefore
    // refuses a push even in a cycle that pops.
    assign fpu_ready_o   = ~fifo_full;
    assign ex_ready_o    = ~lsu_we_i & ~(starved & fifo_nonempty);
    assign fpu_pending_o = fifo_nonempty;
    assign push          = fpu_valid_i & fpu_ready_o;
    assign pop           = gnt_fifo;

    // Fixed-priority grant. The starved flag swaps the EX and FIFO priorities.
    always_comb begin
        gnt_lsu  = 1'b0;
        gnt_ex   = 1'b0;
        gnt_fifo = 1'b0;
        if (lsu_we_i) begin
            gnt_lsu = 1'b1;
        end else if (starved) begin
            if (fifo_nonempty)   gnt_fifo = 1'b1;
            else if (ex_valid_i) gnt_ex   = 1'b1;
        end else begin
            if (ex_valid_i)         gnt_ex   = 1'b1;
            else if (fifo_nonempty) gnt_fifo = 1'b1;
        end
    end

    // Write port mux. All outputs are zero when there is no winner.
    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        rf_fp_o    = 1'b0;
        if (gnt_lsu) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = lsu_waddr_i;
            rf_wdata_o = lsu_wdata_i;
            rf_fp_o    = lsu_fp_i;
        end else if (gnt_ex) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = ex_waddr_i;
            rf_wdata_o = ex_wdata_i;
            rf_fp_o    = ex_fp_i;
        end else if (gnt_fifo) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = head[36:32];
            rf_wdata_o = head[31:0];
            rf_fp_o    = 1'b1;
        end
    end

    // Next state for the pointers, the occupancy count and the starve counter.
    always_comb begin
        wptr_next = wptr_reg;
        rptr_next = rptr_reg;
        cnt_next  = cnt_reg + CntW'(push) - CntW'(pop);
        stv_next  = stv_reg;
        if (push) wptr_next = (wptr_reg == PtrLast) ? '0 : wptr_reg + 1'b1;
        if (pop)  rptr_next = (rptr_reg == PtrLast) ? '0 : rptr_reg + 1'b1;
        if (pop || !fifo_nonempty) begin
            stv_next = '0;
        end else if (!starved) begin
            stv_next = stv_reg + 1'b1;
        end
    end

    // Control state register. An asynchronous reset drops all buffered entries.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
            cnt_reg  <= '0;
            stv_reg  <= '0;
        end else begin
            wptr_reg <= wptr_next;
            rptr_reg <= rptr_next;
            cnt_reg  <= cnt_next;
            stv_reg  <= stv_next;
        end
    end

    // Per-entry storage write. The entry is written on a push to its slot.
    for (genvar gi = 0; gi < FifoDepth; gi++) begin : g_entry
        always_ff @(posedge clk_i) begin
            if (push && (wptr_reg == PtrW'(gi))) begin
                mem_reg[gi] <= {fpu_waddr_i, fpu_wdata_i};
            end
        end
    end

    // Write enable tracks the grants, and at most one grant is active.
    a_we_matches_grant: assert property (@(posedge clk_i)
        rf_we_o == (gnt_lsu | gnt_ex | gnt_fifo));
    a_grant_onehot0: assert property (@(posedge clk_i)
        $onehot0({gnt_lsu, gnt_ex, gnt_fifo}));

endmodule

// File: tb/tb_ibex_wb_port_arbiter.sv
// Directed testbench for ibex_wb_port_arbiter with default parameters
// (FifoDepth=2, StarveLimit=4).
module tb_ibex_wb_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        lsu_we_i, lsu_fp_i;
    logic [4:0]  lsu_waddr_i;
    logic [31:0] lsu_wdata_i;
    logic        ex_valid_i, ex_ready_o, ex_fp_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        fpu_valid_i, fpu_ready_o;
    logic [4:0]  fpu_waddr_i;
    logic [31:0] fpu_wdata_i;
    logic        rf_we_o, rf_fp_o, fpu_pending_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;

    int n_cmp = 0;
    int n_err = 0;

    ibex_wb_port_arbiter #(.FifoDepth(2), .StarveLimit(4)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .lsu_we_i     (lsu_we_i),
        .lsu_waddr_i  (lsu_waddr_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .lsu_fp_i     (lsu_fp_i),
        .ex_valid_i   (ex_valid_i),
        .ex_ready_o   (ex_ready_o),
        .ex_waddr_i   (ex_waddr_i),
        .ex_wdata_i   (ex_wdata_i),
        .ex_fp_i      (ex_fp_i),
        .fpu_valid_i  (fpu_valid_i),
        .fpu_ready_o  (fpu_ready_o),
        .fpu_waddr_i  (fpu_waddr_i),
        .fpu_wdata_i  (fpu_wdata_i),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .rf_fp_o      (rf_fp_o),
        .fpu_pending_o(fpu_pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance to just after the next rising edge, so new inputs apply to the next cycle.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        lsu_we_i = 0; lsu_waddr_i = 0; lsu_wdata_i = 0; lsu_fp_i = 0;
        ex_valid_i = 0; ex_waddr_i = 0; ex_wdata_i = 0; ex_fp_i = 0;
        fpu_valid_i = 0; fpu_waddr_i = 0; fpu_wdata_i = 0;
    endtask

    task automatic fpu_push(input logic [4:0] a, input logic [31:0] d);
        fpu_valid_i = 1; fpu_waddr_i = a; fpu_wdata_i = d;
    endtask

    initial begin
        idle_inputs();
        rst_ni = 0;

        // Reset state
        tick(); #1;
        check_eq("rst_rf_we",      rf_we_o, 0);
        check_eq("rst_rf_waddr",   rf_waddr_o, 0);
        check_eq("rst_rf_wdata",   rf_wdata_o, 0);
        check_eq("rst_rf_fp",      rf_fp_o, 0);
        check_eq("rst_fpu_ready",  fpu_ready_o, 1);
        check_eq("rst_pending",    fpu_pending_o, 0);
        check_eq("rst_ex_ready",   ex_ready_o, 1);
        lsu_we_i = 1; #1;
        check_eq("rst_ex_ready_lsu", ex_ready_o, 0);
        lsu_we_i = 0;
        tick();
        rst_ni = 1;

        // Single FPU push with no bypass: the write happens one cycle later
        tick(); fpu_push(5'd3, 32'h3F80_0000); #1;
        check_eq("p1_c0_we", rf_we_o, 0);
        check_eq("p1_c0_ready", fpu_ready_o, 1);
        tick(); idle_inputs(); #1;
        check_eq("p1_c1_we", rf_we_o, 1);
        check_eq("p1_c1_waddr", rf_waddr_o, 3);
        check_eq("p1_c1_wdata", rf_wdata_o, 32'h3F80_0000);
        check_eq("p1_c1_fp", rf_fp_o, 1);
        tick(); #1;
        check_eq("p1_c2_pending", fpu_pending_o, 0);
        check_eq("p1_c2_we", rf_we_o, 0);

        // The LSU beats both EX and a non-empty buffer
        tick(); fpu_push(5'd5, 32'h0000_AAAA); #1;
        tick(); idle_inputs();
        lsu_we_i = 1; lsu_waddr_i = 5'd7; lsu_wdata_i = 32'h11; lsu_fp_i = 0;
        ex_valid_i = 1; ex_waddr_i = 5'd9; ex_wdata_i = 32'h99; #1;
        check_eq("lsu_we", rf_we_o, 1);
        check_eq("lsu_waddr", rf_waddr_o, 7);
        check_eq("lsu_wdata", rf_wdata_o, 32'h11);
        check_eq("lsu_fp", rf_fp_o, 0);
        check_eq("lsu_ex_ready", ex_ready_o, 0);
        check_eq("lsu_pending", fpu_pending_o, 1);
        tick(); idle_inputs(); #1;
        check_eq("lsu_then_fifo_waddr", rf_waddr_o, 5);
        check_eq("lsu_then_fifo_wdata", rf_wdata_o, 32'h0000_AAAA);
        tick(); #1;
        check_eq("lsu_then_empty", fpu_pending_o, 0);

        // Starvation: EX wins cycles 0-4, the buffer wins cycle 5
        tick(); fpu_push(5'd6, 32'h66);
        ex_valid_i = 1; ex_waddr_i = 5'd2; ex_wdata_i = 32'h22; ex_fp_i = 0; #1;
        check_eq("stv_c0_waddr", rf_waddr_o, 2);
        for (int c = 1; c <= 6; c++) begin
            tick(); fpu_valid_i = 0; #1;
            check_eq($sformatf("stv_c%0d_waddr", c), rf_waddr_o, (c == 5) ? 64'd6 : 64'd2);
            check_eq($sformatf("stv_c%0d_ex_ready", c), ex_ready_o, (c == 5) ? 64'd0 : 64'd1);
        end
        check_eq("stv_c6_pending", fpu_pending_o, 0);
        idle_inputs();

        // Three back-to-back pushes into a 2-deep buffer while EX holds the port
        for (int c = 0; c <= 16; c++) begin
            tick();
            ex_valid_i = 1; ex_waddr_i = 5'd1; ex_wdata_i = 32'h1;
            if (c == 0)      fpu_push(5'd10, 32'hA0);
            else if (c == 1) fpu_push(5'd11, 32'hB0);
            else if (c <= 6) fpu_push(5'd12, 32'hC0);
            else             fpu_valid_i = 0;
            #1;
            if (c == 2 || c == 5) check_eq($sformatf("bp_c%0d_fpu_ready", c), fpu_ready_o, 0);
            if (c == 6)           check_eq("bp_c6_fpu_ready", fpu_ready_o, 1);
            check_eq($sformatf("bp_c%0d_waddr", c), rf_waddr_o,
                     (c == 5) ? 64'd10 : (c == 10) ? 64'd11 : (c == 15) ? 64'd12 : 64'd1);
        end
        check_eq("bp_end_pending", fpu_pending_o, 0);
        idle_inputs();

        // Fill the buffer, pulse reset, and check that the entries are gone
        tick(); ex_valid_i = 1; ex_waddr_i = 5'd4; fpu_push(5'd20, 32'hD0); #1;
        tick(); fpu_push(5'd21, 32'hE0); #1;
        tick(); fpu_valid_i = 0; #1;
        check_eq("rp_full_ready", fpu_ready_o, 0);
        check_eq("rp_full_pending", fpu_pending_o, 1);
        tick(); idle_inputs(); rst_ni = 0; #1;
        check_eq("rp_in_rst_ready", fpu_ready_o, 1);
        check_eq("rp_in_rst_pending", fpu_pending_o, 0);
        tick(); rst_ni = 1; #1;
        check_eq("rp_rel_ready", fpu_ready_o, 1);
        for (int c = 0; c < 6; c++) begin
            tick(); #1;
            check_eq($sformatf("rp_after_c%0d_we", c), rf_we_o, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
